sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 16; number of storage entries, power of two, at least 4.
REQ-002 Parameter WIDTH, default 16; data word width in bits.
REQ-003 Parameter AF_LEVEL, default 12; almost_full_o asserts when count_o >= AF_LEVEL; legal range 1..DEPTH-1.
REQ-004 Parameter AE_LEVEL, default 4; almost_empty_o asserts when count_o <= AE_LEVEL; legal range 1..DEPTH-1.
REQ-005 The port list SHALL be as follows:
  clk_i  in  1  single clock; all logic on posedge.
  rst_i  in  1  synchronous, active-high reset.
  wr_en_i  in  1  write request.
  wdata_i  in  WIDTH  write data.
  rd_en_i  in  1  read request.
  rdata_o  out  WIDTH  registered read data.
  full_o  out  1  FIFO holds DEPTH entries.
  empty_o  out  1  FIFO holds 0 entries.
  wr_error_o  out  1  one-cycle pulse for a write rejected when full.
  rd_error_o  out  1  one-cycle pulse for a read rejected when empty.
  count_o  out  $clog2(DEPTH)+1  current occupancy.
  almost_full_o  out  1  threshold flag; present only with the macro in REQ-020.
  almost_empty_o  out  1  threshold flag; present only with the macro in REQ-020.

Function
REQ-006 Write and read pointers SHALL be $clog2(DEPTH)+1 bits, with the MSB serving as the wrap bit; index = pointer LSBs, wrapping naturally from DEPTH-1 to 0.
REQ-007 full_o SHALL equal 1 when pointer indices match and wrap bits differ, and empty_o SHALL equal 1 when the whole pointers are equal; both are combinational from registered pointers, with zero added latency.
REQ-008 A write is accepted when wr_en_i=1 and full_o=0: mem[wr index] <= wdata_i, and the write pointer increments.
REQ-009 A read is accepted when rd_en_i=1 and empty_o=0: rdata_o <= mem[rd index] on that edge (1-cycle latency), and the read pointer increments; rdata_o otherwise holds its value.
REQ-010 Acceptance SHALL be judged on flags sampled before the edge; a simultaneous read does not admit a write when full, and a simultaneous write does not admit a read when empty.
REQ-011 If both a write and a read are accepted in one cycle, count_o SHALL be unchanged; otherwise it changes by +1 or -1.
REQ-012 wr_error_o SHALL be registered 1 for exactly the cycle after a rejected write, else 0; rd_error_o SHALL follow the same rule for a rejected read.
REQ-013 A rejected operation SHALL NOT change pointers, memory, count_o or rdata_o.
REQ-014 count_o SHALL equal (write pointer - read pointer) modulo 2*DEPTH, and SHALL never exceed DEPTH.

Reset
REQ-015 While rst_i=1 at a posedge: both pointers 0, count_o=0, rdata_o=0, wr_error_o=0, rd_error_o=0; therefore empty_o=1 and full_o=0.
REQ-016 Reset asserted mid-operation SHALL discard all contents in one cycle, and wr_en_i/rd_en_i SHALL be ignored during that cycle.
REQ-017 Memory contents SHALL NOT be cleared by reset; stale data SHALL be unobservable because empty_o=1.
REQ-018 With the macro in REQ-020 defined, reset SHALL give almost_empty_o=1 and almost_full_o=0.

Configuration
REQ-019 Threshold flags are optional.
REQ-020 With SYNC_FIFO_THRESH_EN defined: almost_full_o and almost_empty_o exist and are combinational from count_o per REQ-003/REQ-004, and AF_LEVEL and AE_LEVEL are checked at elaboration.
REQ-021 With SYNC_FIFO_THRESH_EN undefined: the almost_full_o and almost_empty_o ports, their logic and the AF/AE parameters are absent; all other behaviour is identical.

Structure
REQ-022 Package sync_fifo_pkg SHALL hold the default DEPTH/WIDTH/AF_LEVEL/AE_LEVEL constants and a pointer-width function returning $clog2(depth)+1.
REQ-023 Storage SHALL be a sub-module sync_fifo_mem: one write port and one registered read port, parameterised by DEPTH and WIDTH, with no reset.
REQ-024 Pointer, count and flag control SHALL reside in sync_fifo.

Verification (DEPTH=16, WIDTH=16, AF=12, AE=4, macro defined)
REQ-025 Fill and drain: write 0x0000..0x000F, then read 16 -> rdata_o sequence 0x0000..0x000F, each one cycle after rd_en_i; full_o=1 after the 16th write and empty_o=1 after the 16th read.
REQ-026 Overflow: with the FIFO full, wr_en_i=1 and wdata_i=0xDEAD -> wr_error_o=1 for one cycle; count_o stays 16; 0xDEAD is never read.
REQ-027 Underflow plus simultaneous access: from empty, rd_en_i=1 and wr_en_i=1 with 0x1234 -> rd_error_o=1, count_o=1; the next read returns 0x1234.
REQ-028 Steady streaming: with count_o=8, 20 cycles of simultaneous writes and reads -> count_o stays 8 and data order is preserved across pointer wrap.
REQ-029 Thresholds: count_o 11->12 asserts almost_full_o; count_o 5->4 asserts almost_empty_o.
REQ-030 Reset mid-stream: rst_i=1 for one cycle at count_o=9 -> next cycle count_o=0, empty_o=1, rdata_o=0x0000, no error pulses.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and pointer-width helper for sync_fifo
package sync_fifo_pkg;

    localparam int DEFAULT_DEPTH    = 16;
    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_AF_LEVEL = 12;
    localparam int DEFAULT_AE_LEVEL = 4;

    // Pointer carries one extra wrap bit above the storage index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - FIFO storage array, one write port, one registered read port, no reset
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the word at the write index.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: capture the addressed word only on an accepted read, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO top; threshold flags enabled by SYNC_FIFO_THRESH_EN
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH
`ifdef SYNC_FIFO_THRESH_EN
    ,
    parameter int AF_LEVEL = DEFAULT_AF_LEVEL,
    parameter int AE_LEVEL = DEFAULT_AE_LEVEL
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   wr_error_o,
    output logic                   rd_error_o,
    output logic [$clog2(DEPTH):0] count_o
`ifdef SYNC_FIFO_THRESH_EN
    ,
    output logic                   almost_full_o,
    output logic                   almost_empty_o
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 4");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic             rdata_zero;
    logic [WIDTH-1:0] mem_rdata;

    // Flags come straight from the registered pointers; the wrap bit tells full from empty.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count_o = wr_ptr - rd_ptr;

    // Acceptance uses pre-edge flags, so a read never makes room for a same-cycle write.
    assign wr_acc = wr_en_i && !full_o && !rst_i;
    assign rd_acc = rd_en_i && !empty_o && !rst_i;

    // Pointer and error-pulse state; reset drops contents by collapsing both pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            wr_error_o <= wr_en_i && full_o;
            rd_error_o <= rd_en_i && empty_o;
        end
    end

    // The storage read register has no reset, so mask it to zero until the first accepted read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_zero <= 1'b1;
        end else if (rd_acc) begin
            rdata_zero <= 1'b0;
        end
    end

    assign rdata_o = rdata_zero ? '0 : mem_rdata;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr[AW-1:0]),
        .wdata_i (wdata_i),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr[AW-1:0]),
        .rdata_o (mem_rdata)
    );

`ifdef SYNC_FIFO_THRESH_EN
    localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL must be in 1..DEPTH-1");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL must be in 1..DEPTH-1");
    end

    assign almost_full_o  = (count_o >= AF_CNT);
    assign almost_empty_o = (count_o <= AE_CNT);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [15:0] wdata_i;
    logic        rd_en_i;
    logic [15:0] rdata_o;
    logic        full_o;
    logic        empty_o;
    logic        wr_error_o;
    logic        rd_error_o;
    logic [4:0]  count_o;
`ifdef SYNC_FIFO_THRESH_EN
    logic        almost_full_o;
    logic        almost_empty_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    sync_fifo #(
        .DEPTH    (16),
        .WIDTH    (16)
`ifdef SYNC_FIFO_THRESH_EN
        ,
        .AF_LEVEL (12),
        .AE_LEVEL (4)
`endif
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wdata_i        (wdata_i),
        .rd_en_i        (rd_en_i),
        .rdata_o        (rdata_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .wr_error_o     (wr_error_o),
        .rd_error_o     (rd_error_o),
        .count_o        (count_o)
`ifdef SYNC_FIFO_THRESH_EN
        ,
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; wdata_i = '0;
        step();
        step();
        check_eq("rst_count", count_o, 0);
        check_eq("rst_empty", empty_o, 1);
        check_eq("rst_full", full_o, 0);
        check_eq("rst_rdata", rdata_o, 0);
        check_eq("rst_wr_err", wr_error_o, 0);
        check_eq("rst_rd_err", rd_error_o, 0);
`ifdef SYNC_FIFO_THRESH_EN
        check_eq("rst_ae", almost_empty_o, 1);
        check_eq("rst_af", almost_full_o, 0);
`endif
        rst_i = 1'b0;

        // Fill 0x0000..0x000F
        for (int i = 0; i < 16; i++) begin
            wr_en_i = 1'b1; wdata_i = 16'(i);
            step();
            check_eq("fill_count", count_o, i + 1);
`ifdef SYNC_FIFO_THRESH_EN
            check_eq("fill_af", almost_full_o, (i + 1 >= 12) ? 1 : 0);
`endif
        end
        check_eq("fill_full", full_o, 1);
        check_eq("fill_empty", empty_o, 0);

        // Overflow attempt
        wdata_i = 16'hDEAD;
        step();
        check_eq("ovf_wr_err", wr_error_o, 1);
        check_eq("ovf_count", count_o, 16);
        check_eq("ovf_full", full_o, 1);
        wr_en_i = 1'b0;
        step();
        check_eq("ovf_wr_err_clr", wr_error_o, 0);

        // Drain, expecting 0x0000..0x000F one cycle after each read
        for (int i = 0; i < 16; i++) begin
            rd_en_i = 1'b1;
            step();
            check_eq("drain_data", rdata_o, i);
            check_eq("drain_count", count_o, 15 - i);
`ifdef SYNC_FIFO_THRESH_EN
            check_eq("drain_ae", almost_empty_o, (15 - i <= 4) ? 1 : 0);
`endif
        end
        check_eq("drain_empty", empty_o, 1);

        // Underflow with simultaneous write
        wr_en_i = 1'b1; wdata_i = 16'h1234;
        step();
        check_eq("udf_rd_err", rd_error_o, 1);
        check_eq("udf_wr_err", wr_error_o, 0);
        check_eq("udf_count", count_o, 1);
        check_eq("udf_rdata_hold", rdata_o, 16'h000F);
        wr_en_i = 1'b0;
        step();
        check_eq("udf_read", rdata_o, 16'h1234);
        check_eq("udf_rd_err_clr", rd_error_o, 0);
        check_eq("udf_count0", count_o, 0);
        rd_en_i = 1'b0;

        // Prime 8 entries, then stream across the pointer wrap
        for (int k = 0; k < 8; k++) begin
            wr_en_i = 1'b1; wdata_i = 16'(16'h0100 + k);
            step();
        end
        check_eq("stream_prime", count_o, 8);
        for (int k = 0; k < 20; k++) begin
            wr_en_i = 1'b1; rd_en_i = 1'b1; wdata_i = 16'(16'h0108 + k);
            step();
            check_eq("stream_data", rdata_o, 16'h0100 + k);
            check_eq("stream_count", count_o, 8);
        end
        rd_en_i = 1'b0;
        wdata_i = 16'h0200;
        step();
        check_eq("mid_count9", count_o, 9);

        // Reset mid-stream with requests asserted
        rst_i = 1'b1; wr_en_i = 1'b1; rd_en_i = 1'b1; wdata_i = 16'hBEEF;
        step();
        check_eq("mrst_count", count_o, 0);
        check_eq("mrst_empty", empty_o, 1);
        check_eq("mrst_rdata", rdata_o, 0);
        check_eq("mrst_wr_err", wr_error_o, 0);
        check_eq("mrst_rd_err", rd_error_o, 0);
        rst_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b1;
        step();
        check_eq("post_rst_rd_err", rd_error_o, 1);
        check_eq("post_rst_rdata", rdata_o, 0);
        check_eq("post_rst_count", count_o, 0);
        rd_en_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
